// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//
// Purpose:
//   Synchronous pulse-train generator. A start request in IDLE latches a
//   pulse count N, a high time H and a low time L. The block then drives N
//   square pulses on sig_o. Each pulse is H cycles high followed by L cycles
//   low. A one-cycle done_o strobe follows the last low cycle. edge_o marks
//   the first cycle of every high phase, so a downstream edge detector can
//   be compared against it cycle by cycle.
//
// Optional feature:
//   PULSE_TRAIN_GEN_ABORT_EN - when defined, the abort_i port exists.
//   abort_i in HIGH or LOW ends the train through the DONE state.
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst      - synchronous active-high reset
//   start_i  - start request, sampled only in IDLE
//   num_i    - number of pulses (N_W bits)
//   high_i   - high time per pulse in cycles (W_W bits, 0 treated as 1)
//   low_i    - low time per pulse in cycles (W_W bits, 0 treated as 1)
//   abort_i  - abort request (only with PULSE_TRAIN_GEN_ABORT_EN)
//   sig_o    - generated waveform
//   edge_o   - high in the first cycle of each high phase
//   busy_o   - high in every state other than IDLE
//   done_o   - one-cycle completion strobe
// ---------------------------------------------------------------------------
module pulse_train_gen #(
  parameter int W_W = 8,
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [N_W-1:0] num_i,
  input  logic [W_W-1:0] high_i,
  input  logic [W_W-1:0] low_i,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic           abort_i,
`endif
  output logic           sig_o,
  output logic           edge_o,
  output logic           busy_o,
  output logic           done_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [W_W-1:0] ONE_W = W_W'(1);
  localparam logic [N_W-1:0] ONE_N = N_W'(1);

  state_t         state_reg,  state_next;
  logic [W_W-1:0] phase_reg,  phase_next;   // cycles left in the current phase, minus one
  logic [N_W-1:0] remain_reg, remain_next;  // pulses left, including the current one
  logic [W_W-1:0] high_reg,   high_next;    // latched H-1
  logic [W_W-1:0] low_reg,    low_next;     // latched L-1
  logic           first_reg,  first_next;   // first cycle of a high phase

  logic           abort_req;
  logic [W_W-1:0] high_m1;
  logic [W_W-1:0] low_m1;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // The phase counter holds "cycles - 1", so a zero time clamps to one cycle.
  assign high_m1 = (high_i == '0) ? '0 : high_i - ONE_W;
  assign low_m1  = (low_i  == '0) ? '0 : low_i  - ONE_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      phase_reg  <= '0;
      remain_reg <= '0;
      high_reg   <= '0;
      low_reg    <= '0;
      first_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      remain_reg <= remain_next;
      high_reg   <= high_next;
      low_reg    <= low_next;
      first_reg  <= first_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    remain_next = remain_reg;
    high_next   = high_reg;
    low_next    = low_reg;
    first_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          high_next = high_m1;
          low_next  = low_m1;
          if (num_i != '0) begin
            state_next  = HIGH;
            phase_next  = high_m1;
            remain_next = num_i;
            first_next  = 1'b1;
          end else begin
            state_next  = DONE;
          end
        end
      end

      HIGH: begin
        if (abort_req) begin
          state_next = DONE;
        end else if (phase_reg == '0) begin
          state_next = LOW;
          phase_next = low_reg;
        end else begin
          phase_next = phase_reg - ONE_W;
        end
      end

      LOW: begin
        if (abort_req) begin
          state_next = DONE;
        end else if (phase_reg == '0) begin
          if (remain_reg == ONE_N) begin
            state_next = DONE;
          end else begin
            state_next  = HIGH;
            phase_next  = high_reg;
            remain_next = remain_reg - ONE_N;
            first_next  = 1'b1;
          end
        end else begin
          phase_next = phase_reg - ONE_W;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state only.
  assign sig_o  = (state_reg == HIGH);
  assign edge_o = (state_reg == HIGH) && first_reg;
  assign busy_o = (state_reg != IDLE);
  assign done_o = (state_reg == DONE);

endmodule

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
//
// Scoreboard bench for pulse_train_gen. The stimulus pushes the expected
// outputs for each cycle, tagged with the cycle number, into a queue. A
// monitor on the falling edge pops every entry due in the current cycle and
// compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] num_i = '0;
  logic [7:0] high_i = '0;
  logic [7:0] low_i = '0;
  logic       abort_i = 1'b0;
  logic       sig_o, edge_o, busy_o, done_o;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int base = 0;

  typedef struct {
    int   cyc;
    logic s;
    logic e;
    logic b;
    logic d;
  } exp_t;

  exp_t q[$];

  pulse_train_gen #(.W_W(8), .N_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .num_i   (num_i),
    .high_i  (high_i),
    .low_i   (low_i),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort_i (abort_i),
`endif
    .sig_o   (sig_o),
    .edge_o  (edge_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || sig_o !== e.s || edge_o !== e.e ||
          busy_o !== e.b || done_o !== e.d) begin
        fails++;
        $display("FAIL outputs cyc=%0d (due %0d): got sig=%b edge=%b busy=%b done=%b, need sig=%b edge=%b busy=%b done=%b",
                 cyc, e.cyc, sig_o, edge_o, busy_o, done_o, e.s, e.e, e.b, e.d);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input int off, input logic s, input logic e,
                          input logic b, input logic d);
    exp_t x;
    x.cyc = base + off;
    x.s = s; x.e = e; x.b = b; x.d = d;
    q.push_back(x);
  endtask

  // Strings list the expected value for offsets 1..len after the accept edge.
  task automatic push_str(input string s, input string e, input string b,
                          input string d);
    for (int i = 0; i < s.len(); i++)
      push_one(i + 1, s.getc(i) == "1", e.getc(i) == "1",
               b.getc(i) == "1", d.getc(i) == "1");
  endtask

  task automatic issue(input int n, input int h, input int l);
    base    = cyc;
    start_i = 1'b1;
    num_i   = 8'(n);
    high_i  = 8'(h);
    low_i   = 8'(l);
  endtask

  // Full train: start now, check offsets 1..len, end sitting in offset len.
  task automatic train(input int n, input int h, input int l, input string s,
                       input string e, input string b, input string d);
    issue(n, h, l);
    push_str(s, e, b, d);
    step(1);
    start_i = 1'b0;
    step(s.len() - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with start_i held high to show reset wins.
    step(2);
    base = cyc;
    start_i = 1'b1;
    num_i = 8'd3; high_i = 8'd2; low_i = 8'd3;
    push_str("000", "000", "000", "000");
    step(3);
    rst = 1'b0;
    start_i = 1'b0;
    step(1);

    // Basic train N=3 H=2 L=3.
    train(3, 2, 3, "11000110001100000", "10000100001000000",
                   "11111111111111110", "00000000000000010");

    // Zero count, back to back from the idle cycle above.
    train(0, 5, 5, "00", "00", "10", "10");

    // Zero-time clamp.
    train(2, 0, 0, "101000", "101000", "111110", "000010");

    // Starts while busy (offset 2 in HIGH, offset 9 in DONE) are dropped.
    issue(1, 4, 4);
    push_str("11110000000", "10000000000", "11111111100", "00000000100");
    step(1);
    start_i = 1'b0;
    step(1);
    start_i = 1'b1; num_i = 8'd3; high_i = 8'd1; low_i = 8'd1;
    step(1);
    start_i = 1'b0;
    step(6);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(1);

    // Reset mid-train at offset 7, then a short train.
    issue(5, 3, 3);
    push_str("111000100", "100000100", "111111100", "000000000");
    step(1);
    start_i = 1'b0;
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    train(1, 1, 1, "1000", "1000", "1110", "0010");

    // Maximum high time: H=255, L=0 (clamped to 1), N=1.
    issue(1, 255, 0);
    for (int o = 1; o <= 255; o++) push_one(o, 1'b1, o == 1, 1'b1, 1'b0);
    push_one(256, 1'b0, 1'b0, 1'b1, 1'b0);
    push_one(257, 1'b0, 1'b0, 1'b1, 1'b1);
    push_one(258, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    start_i = 1'b0;
    step(257);

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    // Abort during the first low cycle.
    issue(4, 2, 2);
    push_str("11000", "10000", "11110", "00010");
    step(1);
    start_i = 1'b0;
    step(2);
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    step(1);
`endif

    step(3);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
